// File: rtl/aer_in_driver_pkg.sv
// Shared types and constants for the off-core AER input-link driver.
// Holds the handshake FSM state encoding and the event word width.
package odin_aer_pkg;

    localparam int M_DEFAULT = 8;
    localparam int AER_W     = 2 * M_DEFAULT + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        REQ_HI = 3'd2,
        ACK_LO = 3'd3,
        GAP    = 3'd4
    } aer_state_e;

    // Event word width for a given log2(neuron count).
    function automatic int aer_word_w(input int m);
        return 2 * m + 1;
    endfunction

endpackage

// File: rtl/aer_in_driver_if.sv
// Bus bundle for aer_in_driver: the host-side event push port and the AER link.
//
// Event push port: EVT_DATA is transferred on a rising clock edge where both
// EVT_VALID and EVT_READY are high. EVT_READY does not depend on EVT_VALID.
// AER link: 4-phase REQ/ACK handshake; AER_ADDR is stable whenever AER_REQ=1.
interface aer_in_driver_if
    import odin_aer_pkg::*;
#(
    parameter int W = AER_W
);
    logic [W-1:0] EVT_DATA;
    logic         EVT_VALID;
    logic         EVT_READY;
    logic [W-1:0] AER_ADDR;
    logic         AER_REQ;
    logic         AER_ACK;

    // Driver side (aer_in_driver).
    modport master (
        input  EVT_DATA, EVT_VALID, AER_ACK,
        output EVT_READY, AER_ADDR, AER_REQ
    );

    // Host and link-responder side.
    modport slave (
        output EVT_DATA, EVT_VALID, AER_ACK,
        input  EVT_READY, AER_ADDR, AER_REQ
    );
endinterface

// File: rtl/aer_in_driver_fifo.sv
// aer_evt_fifo: synchronous event FIFO with level/full/empty.
// Head word is read combinationally. Push when full and pop when empty are ignored.
module aer_evt_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap modulo DEPTH; level tracks simultaneous push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end
endmodule

// File: rtl/aer_in_driver.sv
// aer_in_driver: sends queued events over the 17-bit AER input link using a
// 4-phase REQ/ACK handshake, with a programmable idle gap after each event.
// Optional feature macro: AER_DRV_TIMEOUT_EN (ACK timeout with sticky error).
module aer_in_driver
    import odin_aer_pkg::*;
#(
    parameter int M         = 8,
    parameter int DEPTH     = 16,
    parameter int TO_CYCLES = 4096
) (
    input  logic                   CLK,
    input  logic                   RST,
    aer_in_driver_if.master        bus,
    input  logic [15:0]            GAP_CYCLES,
    output logic [$clog2(DEPTH):0] FIFO_LEVEL,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR,
    input  logic                   CLR_ERR,
    output aer_state_e             STATE_DBG
);
    localparam int W = aer_word_w(M);

    aer_state_e   state, state_nxt;
    logic         req_q, req_nxt;
    logic [W-1:0] addr_q, addr_nxt;
    logic [15:0]  gap_q, gap_nxt;
    logic         ack_q1, ack_s;
    logic         fifo_pop;
    logic         fifo_full, fifo_empty;
    logic [W-1:0] fifo_head;

    aer_evt_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (bus.EVT_VALID),
        .din   (bus.EVT_DATA),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .level (FIFO_LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AER_DRV_TIMEOUT_EN
    localparam int TO_W = ($clog2(TO_CYCLES + 1) > 13) ? $clog2(TO_CYCLES + 1) : 13;
    logic [TO_W-1:0] to_q, to_nxt;
    logic            err_q, err_nxt;
`else
    localparam int unused_to_cycles = TO_CYCLES;
    logic          unused_clr_err;
    assign unused_clr_err = CLR_ERR;
`endif

    // Two-flop synchroniser for the asynchronous ACK from the core.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_q1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_q1 <= bus.AER_ACK;
            ack_s  <= ack_q1;
        end
    end

    // Handshake FSM state and registered link outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
            gap_q  <= '0;
`ifdef AER_DRV_TIMEOUT_EN
            to_q   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            req_q  <= req_nxt;
            addr_q <= addr_nxt;
            gap_q  <= gap_nxt;
`ifdef AER_DRV_TIMEOUT_EN
            to_q   <= to_nxt;
            err_q  <= err_nxt;
`endif
        end
    end

    // Next-state logic: decisions use the synchronised ack_s only.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        addr_nxt  = addr_q;
        gap_nxt   = gap_q;
        fifo_pop  = 1'b0;
`ifdef AER_DRV_TIMEOUT_EN
        to_nxt    = to_q;
        err_nxt   = CLR_ERR ? 1'b0 : err_q;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && !ack_s) begin
                    fifo_pop  = 1'b1;
                    addr_nxt  = fifo_head;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                req_nxt   = 1'b1;
                state_nxt = REQ_HI;
`ifdef AER_DRV_TIMEOUT_EN
                to_nxt    = '0;
`endif
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ACK_LO;
                end
`ifdef AER_DRV_TIMEOUT_EN
                else if (to_q == TO_W'(TO_CYCLES - 1)) begin
                    // No ACK in time: abandon this event and recover the link.
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = ACK_LO;
                end else begin
                    to_nxt = to_q + TO_W'(1);
                end
`endif
            end
            ACK_LO: begin
                if (!ack_s) begin
                    if (GAP_CYCLES == 16'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_CYCLES;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q <= 16'd1) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_q - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.AER_REQ   = req_q;
    assign bus.AER_ADDR  = addr_q;
    assign bus.EVT_READY = !fifo_full;
    assign BUSY          = (state != IDLE) || (FIFO_LEVEL != '0);
    assign STATE_DBG     = state;
`ifdef AER_DRV_TIMEOUT_EN
    assign TIMEOUT_ERR   = err_q;
`else
    assign TIMEOUT_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_aer_in_driver.sv
// Directed self-checking bench for aer_in_driver with a delayed-ACK link responder.
// The timeout scenario is compiled in when AER_DRV_TIMEOUT_EN is defined.
module tb_aer_in_driver;
    import odin_aer_pkg::*;

    localparam int W     = 17;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] GAP_CYCLES = 16'd0;
    logic [4:0]  FIFO_LEVEL;
    logic        BUSY;
    logic        TIMEOUT_ERR;
    logic        CLR_ERR = 1'b0;
    aer_state_e  STATE_DBG;

    aer_in_driver_if #(.W(W)) bus ();

    aer_in_driver #(.M(8), .DEPTH(DEPTH), .TO_CYCLES(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .GAP_CYCLES  (GAP_CYCLES),
        .FIFO_LEVEL  (FIFO_LEVEL),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .CLR_ERR     (CLR_ERR),
        .STATE_DBG   (STATE_DBG)
    );

    // Clock and cycle counter
    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           rise_q[$];
    int           n_checks = 0;
    int           n_fails  = 0;
    int           hs_count = 0;
    bit           resp_en  = 1'b1;
    bit           ack_hold = 1'b0;
    int           ack_dly  = 3;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic push_evt(input logic [W-1:0] d, output bit accepted);
        @(negedge CLK);
        accepted = bus.EVT_READY;
        bus.EVT_DATA  = d;
        bus.EVT_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.EVT_VALID = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic wait_busy_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!BUSY) break;
            @(posedge CLK);
            #1;
        end
        check_eq(tag, 32'(BUSY), 32'd0);
    endtask

    task automatic wait_req_high(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.AER_REQ) break;
            @(posedge CLK);
            #1;
        end
        check_eq(tag, 32'(bus.AER_REQ), 32'd1);
    endtask

    // Link responder: ACK follows REQ after ack_dly cycles in both directions;
    // checks every sent address against the expected queue and its stability.
    initial begin
        logic [W-1:0] cap;
        bus.AER_ACK = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (resp_en && bus.AER_REQ && !bus.AER_ACK) begin
                cap = bus.AER_ADDR;
                hs_count++;
                rise_q.push_back(cyc);
                if (exp_q.size() == 0) check_eq("sb_unexpected_evt", 32'(cap), 32'h1ffff);
                else                   check_eq("sb_addr", 32'(cap), 32'(exp_q.pop_front()));
                repeat (ack_dly) @(posedge CLK);
                #2;
                bus.AER_ACK = 1'b1;
                for (int i = 0; i < 1000 && bus.AER_REQ; i++) begin
                    check_eq("addr_stable", 32'(bus.AER_ADDR), 32'(cap));
                    @(posedge CLK);
                    #2;
                end
                check_eq("req_drop", 32'(bus.AER_REQ), 32'd0);
                repeat (ack_dly) @(posedge CLK);
                #2;
                bus.AER_ACK = 1'b0;
            end else begin
                bus.AER_ACK = ack_hold;
            end
        end
    end

    // Main sequence
    initial begin
        bit acc;
        int hs0;
        int p0;
        int p1;
        int n;
        bus.EVT_DATA  = '0;
        bus.EVT_VALID = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("rst_req",   32'(bus.AER_REQ),   32'd0);
        check_eq("rst_addr",  32'(bus.AER_ADDR),  32'd0);
        check_eq("rst_level", 32'(FIFO_LEVEL),    32'd0);
        check_eq("rst_ready", 32'(bus.EVT_READY), 32'd1);
        check_eq("rst_busy",  32'(BUSY),          32'd0);
        check_eq("rst_err",   32'(TIMEOUT_ERR),   32'd0);
        check_eq("rst_state", 32'(STATE_DBG),     32'(IDLE));

        // 1: single event, push-to-REQ latency
        hs0 = hs_count;
        push_evt(17'h1_2345, acc);
        check_eq("t1_accept", 32'(acc), 32'd1);
        check_eq("t1_level_k", 32'(FIFO_LEVEL), 32'd1);
        @(posedge CLK);
        #1;
        check_eq("t1_addr_k1", 32'(bus.AER_ADDR), 32'h1_2345);
        check_eq("t1_req_k1",  32'(bus.AER_REQ),  32'd0);
        check_eq("t1_level_k1", 32'(FIFO_LEVEL),  32'd0);
        @(posedge CLK);
        #1;
        check_eq("t1_req_k2", 32'(bus.AER_REQ), 32'd1);
        wait_busy_idle("t1_busy_idle", 200);
        check_eq("t1_hs_count", 32'(hs_count - hs0), 32'd1);
        check_eq("t1_addr_hold", 32'(bus.AER_ADDR), 32'h1_2345);

        // 2: fill FIFO with ACK held high, refuse 17th push, drain in order
        ack_hold = 1'b1;
        repeat (4) @(posedge CLK);
        hs0 = hs_count;
        for (int i = 0; i < DEPTH; i++) begin
            push_evt(17'(32'h0_1000 + i * 32'h111), acc);
            check_eq("t2_accept", 32'(acc), 32'd1);
        end
        check_eq("t2_level_full", 32'(FIFO_LEVEL), 32'd16);
        check_eq("t2_ready_full", 32'(bus.EVT_READY), 32'd0);
        push_evt(17'h1_ffff, acc);
        check_eq("t2_refused", 32'(acc), 32'd0);
        check_eq("t2_level_still", 32'(FIFO_LEVEL), 32'd16);
        ack_hold = 1'b0;
        wait_req_high("t2_req_rise", 50);
        check_eq("t2_level_15", 32'(FIFO_LEVEL), 32'd15);
        wait_busy_idle("t2_busy_idle", 2000);
        check_eq("t2_hs_count", 32'(hs_count - hs0), 32'd16);
        check_eq("t2_exp_empty", 32'(exp_q.size()), 32'd0);
        check_eq("t2_level_0", 32'(FIFO_LEVEL), 32'd0);

        // 3: inter-event spacing grows by exactly GAP_CYCLES
        ack_dly = 3;
        GAP_CYCLES = 16'd0;
        rise_q.delete();
        push_evt(17'h0_0aaa, acc);
        push_evt(17'h1_0555, acc);
        wait_busy_idle("t3_busy_idle_g0", 500);
        check_eq("t3_rises_g0", 32'(rise_q.size()), 32'd2);
        p0 = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : 0;
        GAP_CYCLES = 16'd10;
        rise_q.delete();
        push_evt(17'h0_1234, acc);
        push_evt(17'h1_4321, acc);
        wait_busy_idle("t3_busy_idle_g10", 500);
        check_eq("t3_rises_g10", 32'(rise_q.size()), 32'd2);
        p1 = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : 0;
        check_eq("t3_gap_delta", 32'(p1 - p0), 32'd10);
        GAP_CYCLES = 16'd0;

        // 4: ACK high at start blocks sending until it falls
        ack_hold = 1'b1;
        repeat (4) @(posedge CLK);
        hs0 = hs_count;
        push_evt(17'h0_beef, acc);
        repeat (8) @(posedge CLK);
        #1;
        check_eq("t4_req_blocked", 32'(bus.AER_REQ), 32'd0);
        check_eq("t4_level_held",  32'(FIFO_LEVEL),  32'd1);
        check_eq("t4_state_idle",  32'(STATE_DBG),   32'(IDLE));
        ack_hold = 1'b0;
        wait_busy_idle("t4_busy_idle", 200);
        check_eq("t4_hs_count", 32'(hs_count - hs0), 32'd1);

        // 5: reset during REQ high
        resp_en = 1'b0;
        hs0 = hs_count;
        push_evt(17'h1_1111, acc);
        push_evt(17'h0_2222, acc);
        push_evt(17'h1_3333, acc);
        wait_req_high("t5_req_rise", 50);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_eq("t5_req_async", 32'(bus.AER_REQ), 32'd0);
        check_eq("t5_level",     32'(FIFO_LEVEL),  32'd0);
        check_eq("t5_busy",      32'(BUSY),        32'd0);
        check_eq("t5_addr",      32'(bus.AER_ADDR), 32'd0);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        resp_en = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check_eq("t5_no_req", 32'(bus.AER_REQ), 32'd0);
        check_eq("t5_no_hs",  32'(hs_count - hs0), 32'd0);
        check_eq("t5_ready",  32'(bus.EVT_READY), 32'd1);

`ifdef AER_DRV_TIMEOUT_EN
        // 6: ACK never rises, REQ dropped after 64 cycles
        resp_en = 1'b0;
        push_evt(17'h0_0f0f, acc);
        push_evt(17'h1_f0f0, acc);
        wait_req_high("t6_req_rise", 50);
        n = 0;
        while (bus.AER_REQ && n < 500) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq("t6_req_width", 32'(n), 32'd64);
        check_eq("t6_err_set", 32'(TIMEOUT_ERR), 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        resp_en = 1'b1;
        hs0 = hs_count;
        wait_busy_idle("t6_busy_idle", 300);
        check_eq("t6_next_sent", 32'(hs_count - hs0), 32'd1);
        check_eq("t6_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
        @(negedge CLK);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        check_eq("t6_err_clr", 32'(TIMEOUT_ERR), 32'd0);
`else
        n = 0;
        check_eq("err_tied_low", 32'(TIMEOUT_ERR) + 32'(n), 32'd0);
`endif

        // Final report
        check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        n_fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

endmodule
